// File: rtl/glitch_sequencer.sv
// Glitch sequencer: holds the target in reset, optionally waits for an external
// trigger edge, then emits an offset-delayed train of glitch pulses per arm.
module glitch_sequencer #(
  parameter int CNT_W        = 32,
  parameter int MAX_PULSES   = 8,
  parameter int RST_CYCLES   = 1000,
  parameter int TRIG_TIMEOUT = 0,
  localparam int PC_W        = $clog2(MAX_PULSES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             abort,
  input  logic             trig_mode,
  input  logic             ext_trig,
  input  logic [CNT_W-1:0] offset,
  input  logic [CNT_W-1:0] duration,
  input  logic [CNT_W-1:0] gap,
  input  logic [PC_W-1:0]  pulse_count,
  output logic             reset_n,
  output logic             glitch_n,
  output logic             busy,
  output logic             done,
  output logic             timed_out
);

  typedef enum logic [2:0] {
    IDLE, RESET, WAIT_TRIG, OFFSET, PULSE, GAP, DONE
  } state_t;

  // Counters hold (length - 1) so a full-scale load still yields full-scale cycles.
  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES > 0 ? RST_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LOAD     = CNT_W'(TRIG_TIMEOUT > 0 ? TRIG_TIMEOUT - 1 : 0);
  localparam bit               HAS_TIMEOUT = (TRIG_TIMEOUT != 0);
  localparam logic [PC_W-1:0]  PC_MAX      = PC_W'(MAX_PULSES);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [PC_W-1:0]  pulse_num_reg, pulse_num_next;
  logic             timed_out_next;

  logic [CNT_W-1:0] off_reg, dur_reg, gap_reg;
  logic [PC_W-1:0]  pc_reg;
  logic             trig_mode_reg;
  logic [2:0]       sync_reg;

  logic             accept;
  logic             trig_edge;
  logic [CNT_W-1:0] dur_load;
  logic [PC_W-1:0]  pulse_inc;
  state_t           launch_state;
  logic [CNT_W-1:0] launch_cnt;

  assign accept    = (state_reg == IDLE) && arm && !abort;
  assign trig_edge = sync_reg[1] & ~sync_reg[2];
  assign dur_load  = dur_reg - CNT_W'(1);
  assign pulse_inc = pulse_num_reg + PC_W'(1);

  // Entry into the offset phase; zero-length offsets fall straight through.
  assign launch_state = (off_reg != '0) ? OFFSET : ((pc_reg == '0) ? DONE : PULSE);
  assign launch_cnt   = (off_reg != '0) ? (off_reg - CNT_W'(1)) : dur_load;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    pulse_num_next = pulse_num_reg;
    timed_out_next = timed_out;
    case (state_reg)
      IDLE: begin
        if (arm) begin
          state_next     = RESET;
          cnt_next       = RST_LOAD;
          pulse_num_next = '0;
          timed_out_next = 1'b0;
        end
      end
      RESET: begin
        if (cnt_reg == '0) begin
          if (trig_mode_reg) begin
            state_next = WAIT_TRIG;
            cnt_next   = TO_LOAD;
          end else begin
            state_next = launch_state;
            cnt_next   = launch_cnt;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      WAIT_TRIG: begin
        if (trig_edge) begin
          state_next = launch_state;
          cnt_next   = launch_cnt;
        end else if (HAS_TIMEOUT) begin
          if (cnt_reg == '0) begin
            state_next     = DONE;
            timed_out_next = 1'b1;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
      end
      OFFSET: begin
        if (cnt_reg == '0) begin
          state_next = (pc_reg == '0) ? DONE : PULSE;
          cnt_next   = dur_load;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt_reg == '0) begin
          pulse_num_next = pulse_inc;
          if (pulse_inc == pc_reg) begin
            state_next = DONE;
          end else if (gap_reg == '0) begin
            cnt_next = dur_load;
          end else begin
            state_next = GAP;
            cnt_next   = gap_reg - CNT_W'(1);
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_reg == '0) begin
          state_next = PULSE;
          cnt_next   = dur_load;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next     = IDLE;
      timed_out_next = timed_out;
    end
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      pulse_num_reg <= '0;
      off_reg       <= '0;
      dur_reg       <= CNT_W'(1);
      gap_reg       <= '0;
      pc_reg        <= '0;
      trig_mode_reg <= 1'b0;
      sync_reg      <= '0;
      reset_n       <= 1'b1;
      glitch_n      <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      timed_out     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pulse_num_reg <= pulse_num_next;
      sync_reg      <= {sync_reg[1:0], ext_trig};
      reset_n       <= (state_next != RESET);
      glitch_n      <= (state_next != PULSE);
      busy          <= (state_next != IDLE);
      done          <= (state_next == DONE);
      timed_out     <= timed_out_next;
      if (accept) begin
        off_reg       <= offset;
        dur_reg       <= (duration == '0) ? CNT_W'(1) : duration;
        gap_reg       <= gap;
        pc_reg        <= (pulse_count > PC_MAX) ? PC_MAX : pulse_count;
        trig_mode_reg <= trig_mode;
      end
    end
  end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: a timeline model of each armed sequence is
// checked every cycle, and hand-computed cycle expectations pin that model.
module tb_glitch_sequencer;
  localparam int CNT_W        = 8;
  localparam int MAX_PULSES   = 8;
  localparam int RST_CYCLES   = 4;
  localparam int TRIG_TIMEOUT = 20;
  localparam int PC_W         = $clog2(MAX_PULSES + 1);
  localparam longint NEVER    = 64'h3fff_ffff_ffff_ffff;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic arm = 1'b0;
  logic abort = 1'b0;
  logic trig_mode = 1'b0;
  logic ext_trig = 1'b0;
  logic [CNT_W-1:0] offset = '0;
  logic [CNT_W-1:0] duration = '0;
  logic [CNT_W-1:0] gap = '0;
  logic [PC_W-1:0]  pulse_count = '0;
  logic reset_n, glitch_n, busy, done, timed_out;

  int vectors = 0;
  int miscompares = 0;
  longint cyc = 0;

  glitch_sequencer #(
    .CNT_W(CNT_W), .MAX_PULSES(MAX_PULSES),
    .RST_CYCLES(RST_CYCLES), .TRIG_TIMEOUT(TRIG_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .ext_trig(ext_trig),
    .offset(offset), .duration(duration), .gap(gap), .pulse_count(pulse_count),
    .reset_n(reset_n), .glitch_n(glitch_n), .busy(busy), .done(done),
    .timed_out(timed_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  bit     plan_valid = 1'b0;
  bit     start_known;
  bit     p_mode;
  bit     exp_to = 1'b0;
  longint base, wait_c, start_c, done_c;
  longint t, first, rel, per;
  int     p_off, p_dur, p_gap, p_n;
  logic   pin_prev = 1'b0;
  bit     e_rst, e_gl, e_busy, e_done;

  function automatic longint seq_end(longint s, int off, int dur, int gp, int n);
    if (n == 0) return s + off;
    return s + off + longint'(n) * dur + longint'(n - 1) * gp;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      plan_valid = 1'b0;
      exp_to     = 1'b0;
      pin_prev   = ext_trig;
    end else begin
      t = cyc;
      if (plan_valid && p_mode && !start_known && t == wait_c + TRIG_TIMEOUT) begin
        done_c = t;
        exp_to = 1'b1;
      end
      e_rst = 1'b1; e_gl = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      if (plan_valid && t >= base && t <= done_c) begin
        e_busy = 1'b1;
        if (t < base + RST_CYCLES) e_rst = 1'b0;
        if (t == done_c) e_done = 1'b1;
        if (start_known && p_n > 0) begin
          first = start_c + p_off;
          per   = p_dur + p_gap;
          if (t >= first) begin
            rel = t - first;
            if (rel / per < p_n && rel % per < p_dur) e_gl = 1'b0;
          end
        end
      end
      check("reset_n", reset_n, e_rst);
      check("glitch_n", glitch_n, e_gl);
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("timed_out", timed_out, exp_to);
      // A pin rise during cycle t is seen by the edge detector in t+2.
      if (ext_trig && !pin_prev && plan_valid && p_mode && !start_known &&
          t + 2 >= wait_c && t + 2 <= wait_c + TRIG_TIMEOUT - 1) begin
        start_known = 1'b1;
        start_c     = t + 3;
        done_c      = seq_end(start_c, p_off, p_dur, p_gap, p_n);
      end
      pin_prev = ext_trig;
      if (abort) begin
        plan_valid = 1'b0;
      end else if (arm && !e_busy) begin
        plan_valid = 1'b1;
        base   = t + 1;
        wait_c = base + RST_CYCLES;
        p_off  = int'(offset);
        p_dur  = (duration == '0) ? 1 : int'(duration);
        p_gap  = int'(gap);
        p_n    = (int'(pulse_count) > MAX_PULSES) ? MAX_PULSES : int'(pulse_count);
        p_mode = trig_mode;
        exp_to = 1'b0;
        if (!p_mode) begin
          start_known = 1'b1;
          start_c     = wait_c;
          done_c      = seq_end(start_c, p_off, p_dur, p_gap, p_n);
        end else begin
          start_known = 1'b0;
          done_c      = NEVER;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input longint c);
    while (cyc < c) tick();
  endtask

  task automatic start(input bit mode, input int off, input int dur, input int gp,
                       input int n, output longint c0);
    trig_mode   = mode;
    offset      = CNT_W'(off);
    duration    = CNT_W'(dur);
    gap         = CNT_W'(gp);
    pulse_count = PC_W'(n);
    arm = 1'b1;
    c0  = cyc;
    $display("arm @%0d mode=%0d offset=%0d duration=%0d gap=%0d pulses=%0d",
             c0, mode, off, dur, gp, n);
    tick();
    arm = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    longint c0;
    #1 rst_n = 1'b0;
    #1;
    check("rst reset_n", reset_n, 1'b1);
    check("rst glitch_n", glitch_n, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst timed_out", timed_out, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) tick();

    // Basic mode 0; mid-run offset change and arm during OFFSET must be ignored
    start(1'b0, 10, 3, 0, 1, c0);
    goto(c0 + 3); offset = CNT_W'(50);
    goto(c0 + 4); check("m0 reset_n low c4", reset_n, 1'b0);
    goto(c0 + 5); check("m0 reset_n high c5", reset_n, 1'b1);
    goto(c0 + 8); arm = 1'b1; tick(); arm = 1'b0;
    goto(c0 + 14); check("m0 glitch_n c14", glitch_n, 1'b1);
    goto(c0 + 15); check("m0 glitch_n c15", glitch_n, 1'b0);
    goto(c0 + 17); check("m0 glitch_n c17", glitch_n, 1'b0);
    goto(c0 + 18); check("m0 done c18", done, 1'b1); check("m0 glitch_n c18", glitch_n, 1'b1);
    goto(c0 + 19); check("m0 busy c19", busy, 1'b0);
    goto(c0 + 22);

    // Pulse train with gap, then back-to-back
    start(1'b0, 0, 2, 5, 3, c0);
    goto(c0 + 5);  check("train glitch c5", glitch_n, 1'b0);
    goto(c0 + 7);  check("train glitch c7", glitch_n, 1'b1);
    goto(c0 + 12); check("train glitch c12", glitch_n, 1'b0);
    goto(c0 + 20); check("train glitch c20", glitch_n, 1'b0);
    goto(c0 + 21); check("train done c21", done, 1'b1);
    goto(c0 + 23);
    start(1'b0, 0, 2, 0, 3, c0);
    goto(c0 + 8);  check("gap0 glitch c8", glitch_n, 1'b0);
    goto(c0 + 10); check("gap0 glitch c10", glitch_n, 1'b0);
    goto(c0 + 11); check("gap0 done c11", done, 1'b1); check("gap0 glitch c11", glitch_n, 1'b1);
    goto(c0 + 13);

    // Trigger mode: edge during RESET ignored, later edge launches offset
    start(1'b1, 7, 1, 0, 1, c0);
    goto(c0 + 2);  ext_trig = 1'b1;
    goto(c0 + 6);  ext_trig = 1'b0;
    goto(c0 + 10); ext_trig = 1'b1;
    goto(c0 + 12); check("trig busy waiting", busy, 1'b1);
    goto(c0 + 19); check("trig glitch c19", glitch_n, 1'b1);
    goto(c0 + 20); check("trig glitch pin+10", glitch_n, 1'b0);
    goto(c0 + 21); check("trig done c21", done, 1'b1);
    ext_trig = 1'b0;
    goto(c0 + 24);

    // Timeout with no trigger
    start(1'b1, 3, 2, 0, 2, c0);
    goto(c0 + 24); check("to done c24", done, 1'b0);
    goto(c0 + 25); check("to done c25", done, 1'b1); check("to flag c25", timed_out, 1'b1);
    goto(c0 + 26); check("to busy c26", busy, 1'b0);
    goto(c0 + 28);

    // Next arm clears timed_out; abort during PULSE
    check("to flag held", timed_out, 1'b1);
    start(1'b0, 2, 6, 0, 1, c0);
    check("to flag cleared", timed_out, 1'b0);
    goto(c0 + 8); check("abort glitch c8", glitch_n, 1'b0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort glitch_n", glitch_n, 1'b1);
    check("abort busy", busy, 1'b0);
    goto(c0 + 14);

    // arm and abort together in IDLE
    arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    check("arm+abort busy", busy, 1'b0);
    repeat (2) tick();

    // Edge values
    start(1'b0, 3, 2, 1, 0, c0);
    goto(c0 + 8); check("n0 done c8", done, 1'b1);
    goto(c0 + 10);
    start(1'b0, 0, 0, 3, 1, c0);
    goto(c0 + 5); check("dur0 glitch c5", glitch_n, 1'b0);
    goto(c0 + 6); check("dur0 done c6", done, 1'b1);
    goto(c0 + 8);
    start(1'b0, 0, 1, 1, 15, c0);
    goto(c0 + 19); check("clamp glitch c19", glitch_n, 1'b0);
    goto(c0 + 20); check("clamp done c20", done, 1'b1);
    goto(c0 + 22);
    start(1'b0, 255, 1, 0, 1, c0);
    goto(c0 + 259); check("off255 glitch c259", glitch_n, 1'b1);
    goto(c0 + 260); check("off255 glitch c260", glitch_n, 1'b0);
    goto(c0 + 261); check("off255 done c261", done, 1'b1);
    goto(c0 + 263);

    // Asynchronous reset mid-GAP
    start(1'b0, 0, 2, 5, 3, c0);
    goto(c0 + 8); check("gap busy c8", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset_n", reset_n, 1'b1);
    check("async glitch_n", glitch_n, 1'b1);
    check("async busy", busy, 1'b0);
    check("async done", done, 1'b0);
    check("async timed_out", timed_out, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    check("post reset busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
